reg_file_nzp: RTL and testbench

//   Parametrised LC-3 general-purpose register file: DEPTH x WIDTH storage, one write port, two

---
 rtl/reg_file_nzp_if.sv | 31 +++
 rtl/reg_file_nzp.sv | 98 +++++++++
 tb/tb_reg_file_nzp.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_nzp_if.sv
// Register-file bus: write port, CC load, busy issue, and two read ports.
//   master: datapath/control side (drives write, issue and read addresses)
//   slave : register file (returns read data, busy flags and NZP)
interface reg_file_nzp_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              ld_cc;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic [2:0]        nzp;

  modport master (
    output wr_en, wr_addr, wr_data, ld_cc, issue_en, issue_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, nzp
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, ld_cc, issue_en, issue_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, nzp
  );
endinterface

// File: rtl/reg_file_nzp.sv
// LC-3 general-purpose register file with NZP condition codes and busy scoreboard.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears registers and busy bits, nzp <= 3'b010
//   bus   : reg_file_nzp_if.slave
//           write port (wr_en/wr_addr/wr_data, ld_cc), busy issue (issue_en/issue_addr),
//           two combinational read ports (rd_addr_x -> rd_data_x, rd_busy_x), nzp
// Out-of-range addresses (DEPTH not a power of two) never hit storage: writes are
// dropped, reads return 0 and not-busy, and issues are ignored.
module reg_file_nzp #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter bit          BYPASS = 1'b1
) (
  input logic           clock,
  input logic           reset,
  reg_file_nzp_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [2:0]       nzp_q;

  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] iss_hit;
  logic [DEPTH-1:0] rd_hit_a;
  logic [DEPTH-1:0] rd_hit_b;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             fwd_a;
  logic             fwd_b;
  logic             n_bit;
  logic             z_bit;
  logic [2:0]       nzp_next;

  // One-hot address decodes; only in-range addresses can produce a hit.
  always_comb begin
    wr_hit   = '0;
    iss_hit  = '0;
    rd_hit_a = '0;
    rd_hit_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_hit[i]   = bus.wr_en    && (bus.wr_addr    == ADDR_W'(i));
      iss_hit[i]  = bus.issue_en && (bus.issue_addr == ADDR_W'(i));
      rd_hit_a[i] = (bus.rd_addr_a == ADDR_W'(i));
      rd_hit_b[i] = (bus.rd_addr_b == ADDR_W'(i));
    end
  end

  // Condition codes from the value on the write bus.
  always_comb begin
    n_bit    = bus.wr_data[WIDTH-1];
    z_bit    = (bus.wr_data == '0);
    nzp_next = {n_bit, z_bit, !n_bit && !z_bit};
  end

  // Storage, scoreboard and NZP; issue is OR-ed in after the write clear so a
  // new producer issued in the same cycle keeps the register busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy  <= '0;
      nzp_q <= 3'b010;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
      busy <= (busy & ~wr_hit) | iss_hit;
      if (bus.wr_en && bus.ld_cc) begin
        nzp_q <= nzp_next;
      end
    end
  end

  // Read muxes: AND-OR select over the one-hot decode, out of range yields 0.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      stored_a = stored_a | (regs[i] & {WIDTH{rd_hit_a[i]}});
      stored_b = stored_b | (regs[i] & {WIDTH{rd_hit_b[i]}});
    end
    fwd_a = BYPASS && (|(wr_hit & rd_hit_a));
    fwd_b = BYPASS && (|(wr_hit & rd_hit_b));
  end

  assign bus.rd_data_a = fwd_a ? bus.wr_data : stored_a;
  assign bus.rd_data_b = fwd_b ? bus.wr_data : stored_b;
  assign bus.rd_busy_a = (|(busy & rd_hit_a)) && !fwd_a;
  assign bus.rd_busy_b = (|(busy & rd_hit_b)) && !fwd_b;
  assign bus.nzp       = nzp_q;

endmodule

// File: tb/tb_reg_file_nzp.sv
// Three register-file configurations driven with one stimulus stream:
//   dut0 WIDTH=16 DEPTH=8 BYPASS=1, dut1 WIDTH=16 DEPTH=8 BYPASS=0, dut2 WIDTH=32 DEPTH=6 BYPASS=1.
module tb_reg_file_nzp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_nzp_if #(.WIDTH(16), .ADDR_W(3)) if0 ();
  reg_file_nzp_if #(.WIDTH(16), .ADDR_W(3)) if1 ();
  reg_file_nzp_if #(.WIDTH(32), .ADDR_W(3)) if2 ();

  reg_file_nzp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut0 (.clock(clk), .reset(rst), .bus(if0));
  reg_file_nzp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) dut1 (.clock(clk), .reset(rst), .bus(if1));
  reg_file_nzp #(.WIDTH(32), .DEPTH(6), .BYPASS(1'b1)) dut2 (.clock(clk), .reset(rst), .bus(if2));

  typedef struct {
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ld_cc;
    logic        issue_en;
    logic [2:0]  issue_addr;
    logic [2:0]  rd_a;
    logic [2:0]  rd_b;
  } op_t;

  typedef struct {
    int          c;
    int          cyc;
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic [2:0]  nzp;
  } exp_t;

  exp_t scb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state, one slot per configuration.
  logic [31:0] m_reg  [3][8];
  bit          m_busy [3][8];
  logic [2:0]  m_nzp  [3];
  op_t         prev;

  function automatic int cfg_w(int c);
    return (c == 2) ? 32 : 16;
  endfunction

  function automatic int cfg_d(int c);
    return (c == 2) ? 6 : 8;
  endfunction

  function automatic bit cfg_b(int c);
    return (c != 1);
  endfunction

  function automatic logic [31:0] cfg_mask(int c);
    return (c == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Sign/zero classification of a WIDTH-bit value.
  function automatic logic [2:0] cc_of(logic [31:0] v, int w);
    if (v == 32'd0) return 3'b010;
    if (v >= (32'd1 << (w - 1))) return 3'b100;
    return 3'b001;
  endfunction

  function automatic op_t mk(bit r, bit we, int wa, logic [31:0] wd, bit cc,
                             bit ie, int ia, int ra, int rb);
    op_t o;
    o.reset      = r;
    o.wr_en      = we;
    o.wr_addr    = 3'(wa);
    o.wr_data    = wd;
    o.ld_cc      = cc;
    o.issue_en   = ie;
    o.issue_addr = 3'(ia);
    o.rd_a       = 3'(ra);
    o.rd_b       = 3'(rb);
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [31:0] d;
    case ($urandom_range(0, 3))
      0:       d = 32'd0;
      1:       d = 32'h8000_8000 | $urandom;
      default: d = $urandom;
    endcase
    o = mk($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), d,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    return o;
  endfunction

  // Architectural effect of an operation at the clock edge.
  task automatic commit(input op_t o);
    for (int c = 0; c < 3; c++) begin
      logic [31:0] v;
      v = o.wr_data & cfg_mask(c);
      if (o.reset) begin
        for (int i = 0; i < 8; i++) begin
          m_reg[c][i]  = 32'd0;
          m_busy[c][i] = 1'b0;
        end
        m_nzp[c] = 3'b010;
      end else begin
        if (o.wr_en && (int'(o.wr_addr) < cfg_d(c))) begin
          m_reg[c][o.wr_addr]  = v;
          m_busy[c][o.wr_addr] = 1'b0;
        end
        if (o.wr_en && o.ld_cc) m_nzp[c] = cc_of(v, cfg_w(c));
        if (o.issue_en && (int'(o.issue_addr) < cfg_d(c))) m_busy[c][o.issue_addr] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_data(int c, op_t o, logic [2:0] a);
    if (int'(a) >= cfg_d(c)) return 32'd0;
    if (cfg_b(c) && o.wr_en && (o.wr_addr == a)) return o.wr_data & cfg_mask(c);
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, op_t o, logic [2:0] a);
    if (int'(a) >= cfg_d(c)) return 1'b0;
    if (cfg_b(c) && o.wr_en && (o.wr_addr == a)) return 1'b0;
    return m_busy[c][a];
  endfunction

  task automatic drive(input op_t o);
    rst            = o.reset;
    if0.wr_en      = o.wr_en;    if1.wr_en      = o.wr_en;    if2.wr_en      = o.wr_en;
    if0.wr_addr    = o.wr_addr;  if1.wr_addr    = o.wr_addr;  if2.wr_addr    = o.wr_addr;
    if0.wr_data    = o.wr_data[15:0];
    if1.wr_data    = o.wr_data[15:0];
    if2.wr_data    = o.wr_data;
    if0.ld_cc      = o.ld_cc;    if1.ld_cc      = o.ld_cc;    if2.ld_cc      = o.ld_cc;
    if0.issue_en   = o.issue_en; if1.issue_en   = o.issue_en; if2.issue_en   = o.issue_en;
    if0.issue_addr = o.issue_addr;
    if1.issue_addr = o.issue_addr;
    if2.issue_addr = o.issue_addr;
    if0.rd_addr_a  = o.rd_a;     if1.rd_addr_a  = o.rd_a;     if2.rd_addr_a  = o.rd_a;
    if0.rd_addr_b  = o.rd_b;     if1.rd_addr_b  = o.rd_b;     if2.rd_addr_b  = o.rd_b;
  endtask

  // One cycle: retire the previous op into the model, apply the new one, queue expectations.
  task automatic step(input op_t o);
    @(posedge clk);
    #1;
    commit(prev);
    drive(o);
    cyc++;
    for (int c = 0; c < 3; c++) begin
      exp_t e;
      e.c   = c;
      e.cyc = cyc;
      e.da  = exp_data(c, o, o.rd_a);
      e.db  = exp_data(c, o, o.rd_b);
      e.ba  = exp_busy(c, o, o.rd_a);
      e.bb  = exp_busy(c, o, o.rd_b);
      e.nzp = m_nzp[c];
      scb.push_back(e);
    end
    prev = o;
  endtask

  task automatic chk(input string name, input int c, input int cy,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, c, cy, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (scb.size() > 0) begin
        exp_t e;
        logic [31:0] da, db;
        logic        ba, bb;
        logic [2:0]  nz;
        e = scb.pop_front();
        case (e.c)
          0: begin
            da = {16'h0, if0.rd_data_a}; db = {16'h0, if0.rd_data_b};
            ba = if0.rd_busy_a; bb = if0.rd_busy_b; nz = if0.nzp;
          end
          1: begin
            da = {16'h0, if1.rd_data_a}; db = {16'h0, if1.rd_data_b};
            ba = if1.rd_busy_a; bb = if1.rd_busy_b; nz = if1.nzp;
          end
          default: begin
            da = if2.rd_data_a; db = if2.rd_data_b;
            ba = if2.rd_busy_a; bb = if2.rd_busy_b; nz = if2.nzp;
          end
        endcase
        chk("rd_data_a", e.c, e.cyc, da, e.da);
        chk("rd_data_b", e.c, e.cyc, db, e.db);
        chk("rd_busy_a", e.c, e.cyc, 32'(ba), 32'(e.ba));
        chk("rd_busy_b", e.c, e.cyc, 32'(bb), 32'(e.bb));
        chk("nzp", e.c, e.cyc, 32'(nz), 32'(e.nzp));
      end
    end
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[c][i]  = 32'd0;
        m_busy[c][i] = 1'b0;
      end
      m_nzp[c] = 3'b010;
    end
    prev = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(prev);

    // Reset, then read every register on both ports.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) step(mk(0, 0, 0, 0, 0, 0, 0, i, 7 - i));

    // NZP from writes to R3.
    step(mk(0, 1, 3, 32'h0000_8001, 1, 0, 0, 3, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3, 0));
    step(mk(0, 1, 3, 32'h0, 1, 0, 0, 3, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3, 0));
    step(mk(0, 1, 3, 32'h0000_0005, 0, 0, 0, 3, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3, 3));

    // Bypass of a same-cycle write.
    step(mk(0, 1, 5, 32'h0000_BEEF, 0, 0, 0, 5, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 5, 5));

    // Scoreboard: issue, write-clear, issue+write in the same cycle.
    step(mk(0, 0, 0, 0, 0, 1, 2, 2, 2));
    step(mk(0, 1, 2, 32'h0000_1234, 0, 0, 0, 2, 2));
    step(mk(0, 0, 0, 0, 0, 0, 0, 2, 2));
    step(mk(0, 1, 2, 32'h0000_0077, 0, 1, 2, 2, 2));
    step(mk(0, 0, 0, 0, 0, 1, 2, 2, 2));
    step(mk(0, 0, 0, 0, 0, 0, 0, 2, 2));

    // Reset overrides a concurrent write and discards busy state.
    step(mk(0, 1, 1, 32'h0000_FFFF, 1, 0, 0, 1, 4));
    step(mk(0, 0, 0, 0, 0, 1, 4, 1, 4));
    step(mk(1, 1, 1, 32'h0000_0001, 1, 1, 4, 1, 4));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 4));

    // Out-of-range addresses on the DEPTH=6 instance.
    step(mk(0, 1, 7, 32'hDEAD_BEEF, 1, 1, 7, 6, 7));
    step(mk(0, 1, 6, 32'h8000_0000, 1, 1, 6, 6, 7));
    step(mk(0, 0, 0, 0, 0, 0, 0, 6, 7));
    step(mk(0, 1, 5, 32'h7FFF_FFFF, 1, 0, 0, 5, 6));
    step(mk(0, 0, 0, 0, 0, 0, 0, 5, 7));

    for (int k = 0; k < 600; k++) step(rand_op());

    @(negedge clk);
    #1;
    for (int k = 0; k < 10 && scb.size() > 0; k++) @(negedge clk);
    if (scb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
